// File: rtl/eth_mmio_axil_bridge.sv
// AXI4-Lite slave to Ethernet controller MMIO bridge.
// Handles one transaction at a time. Write strobes are decoded into an op_size.
// Reads and writes that arrive together are granted round-robin.
// Each read is bounded by a timeout that returns SLVERR.
`timescale 1ns/1ps
module eth_mmio_axil_bridge #(
  parameter int unsigned data_width_p = 64,
  parameter int unsigned addr_width_p = 16,
  parameter int unsigned timeout_p    = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [31:0]               s_axil_awaddr_i,
  input  logic                      s_axil_awvalid_i,
  output logic                      s_axil_awready_o,
  input  logic [data_width_p-1:0]   s_axil_wdata_i,
  input  logic [data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                      s_axil_wvalid_i,
  output logic                      s_axil_wready_o,
  output logic [1:0]                s_axil_bresp_o,
  output logic                      s_axil_bvalid_o,
  input  logic                      s_axil_bready_i,
  input  logic [31:0]               s_axil_araddr_i,
  input  logic                      s_axil_arvalid_i,
  output logic                      s_axil_arready_o,
  output logic [data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                s_axil_rresp_o,
  output logic                      s_axil_rvalid_o,
  input  logic                      s_axil_rready_i,
  output logic [addr_width_p-1:0]   addr_o,
  output logic                      write_en_o,
  output logic                      read_en_o,
  output logic [1:0]                op_size_o,
  output logic [data_width_p-1:0]   write_data_o,
  input  logic [data_width_p-1:0]   read_data_i,
  input  logic                      read_data_v_i
);

  localparam int         StrbW       = int'(data_width_p / 8);
  localparam int         LsbW        = $clog2(StrbW);
  localparam logic [1:0] FullSize    = (data_width_p == 64) ? 2'd3 : 2'd2;
  localparam logic [7:0] TimeoutLast = 8'(timeout_p - 1);
  localparam logic [1:0] RespOkay    = 2'b00;
  localparam logic [1:0] RespSlvErr  = 2'b10;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrIssue = 3'd1;
  localparam logic [2:0] StWrResp  = 3'd2;
  localparam logic [2:0] StRdIssue = 3'd3;
  localparam logic [2:0] StRdWait  = 3'd4;
  localparam logic [2:0] StRdResp  = 3'd5;

  logic [2:0]              state_q, state_d;
  logic                    ptr_wr_q, ptr_wr_d;   // 1: write wins the next tie
  logic                    en_q;                 // holds off handshakes for one cycle after reset
  logic                    legal_q, legal_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic [data_width_p-1:0] wdata_q, wdata_d;

  logic                    strb_legal;
  logic [1:0]              strb_size;
  logic [LsbW-1:0]         strb_off;
  logic [StrbW-1:0]        mask;
  logic                    grant_wr, grant_rd, idle;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{s_axil_awaddr_i[31:addr_width_p], s_axil_awaddr_i[LsbW-1:0],
                              s_axil_araddr_i[31:addr_width_p], s_axil_araddr_i[LsbW-1:0]};

  // Match the strobe against every naturally aligned contiguous lane group.
  always_comb begin
    strb_legal = 1'b0;
    strb_size  = 2'd0;
    strb_off   = '0;
    mask       = '0;
    for (int sz = 0; sz < 4; sz++) begin
      for (int off = 0; off < StrbW; off++) begin
        if (((1 << sz) <= StrbW) && ((off % (1 << sz)) == 0)) begin
          for (int b = 0; b < StrbW; b++) begin
            mask[b] = (b >= off) && (b < off + (1 << sz));
          end
          if (s_axil_wstrb_i == mask) begin
            strb_legal = 1'b1;
            strb_size  = 2'(sz);
            strb_off   = LsbW'(off);
          end
        end
      end
    end
  end

  // Round-robin grant among eligible requests; only evaluated in IDLE.
  always_comb begin
    idle     = (state_q == StIdle) && en_q;
    grant_wr = idle && s_axil_awvalid_i && s_axil_wvalid_i &&
               (ptr_wr_q || !s_axil_arvalid_i);
    grant_rd = idle && s_axil_arvalid_i && !grant_wr;
  end

  // Transaction sequencing and next-state of the latched request/response.
  always_comb begin
    state_d  = state_q;
    ptr_wr_d = ptr_wr_q;
    legal_d  = legal_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    case (state_q)
      StIdle: begin
        if (grant_wr) begin
          addr_d   = {s_axil_awaddr_i[addr_width_p-1:LsbW], strb_off};
          size_d   = strb_size;
          wdata_d  = s_axil_wdata_i;
          legal_d  = strb_legal;
          ptr_wr_d = 1'b0;
          state_d  = StWrIssue;
        end else if (grant_rd) begin
          addr_d   = {s_axil_araddr_i[addr_width_p-1:LsbW], {LsbW{1'b0}}};
          size_d   = FullSize;
          ptr_wr_d = 1'b1;
          state_d  = StRdIssue;
        end
      end
      StWrIssue: begin
        bresp_d = legal_q ? RespOkay : RespSlvErr;
        state_d = StWrResp;
      end
      StWrResp: if (s_axil_bready_i) state_d = StIdle;
      StRdIssue: begin
        cnt_d   = 8'd0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (read_data_v_i) begin
          rdata_d = read_data_i;
          rresp_d = RespOkay;
          state_d = StRdResp;
        end else if (cnt_q == TimeoutLast) begin
          rdata_d = '0;
          rresp_d = RespSlvErr;
          state_d = StRdResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRdResp: if (s_axil_rready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      ptr_wr_q <= 1'b1;
      en_q     <= 1'b0;
      legal_q  <= 1'b0;
      bresp_q  <= 2'b00;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      size_q   <= 2'd0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_wr_q <= ptr_wr_d;
      en_q     <= 1'b1;
      legal_q  <= legal_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
    end
  end

  assign s_axil_awready_o = grant_wr;
  assign s_axil_wready_o  = grant_wr;
  assign s_axil_arready_o = grant_rd;
  assign s_axil_bvalid_o  = (state_q == StWrResp);
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_rvalid_o  = (state_q == StRdResp);
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;
  assign write_en_o       = (state_q == StWrIssue) && legal_q;
  assign read_en_o        = (state_q == StRdIssue);
  assign addr_o           = addr_q;
  assign op_size_o        = size_q;
  assign write_data_o     = wdata_q;

endmodule

// File: doc/eth_mmio_axil_bridge.md
Name: eth_mmio_axil_bridge

Overview:
AXI4-Lite slave that converts host register accesses into the Ethernet controller's single-request MMIO interface (addr, write/read enables, op_size, sync read data with valid). It sits directly upstream of the Ethernet controller wrapper on the Zedboard, between the PS GP AXI interconnect and the controller. It serialises requests one at a time, derives op_size from write strobes, arbitrates reads against writes, and bounds each read with a timeout.

Parameters:
data_width_p, 64, AXI data width; equals the controller's axis_width_p; must be 32 or 64
addr_width_p, 16, controller address width; the AXI address is truncated to these low bits
timeout_p, 255, maximum cycles RD_WAIT holds before returning SLVERR; 8-bit counter

Ports:
clk_i  in  1  sole clock, same domain as the controller clk_i
reset_n_i  in  1  asynchronous active-low reset
s_axil_awaddr_i  in  32  write address
s_axil_awvalid_i / s_axil_awready_o  in/out  1  AW handshake
s_axil_wdata_i  in  data_width_p  write data
s_axil_wstrb_i  in  data_width_p/8  write strobes
s_axil_wvalid_i / s_axil_wready_o  in/out  1  W handshake
s_axil_bresp_o  out  2  write response: 00 OKAY, 10 SLVERR
s_axil_bvalid_o / s_axil_bready_i  out/in  1  B handshake
s_axil_araddr_i  in  32  read address
s_axil_arvalid_i / s_axil_arready_o  in/out  1  AR handshake
s_axil_rdata_o  out  data_width_p  read data
s_axil_rresp_o  out  2  read response
s_axil_rvalid_o / s_axil_rready_i  out/in  1  R handshake
addr_o  out  addr_width_p  controller address
write_en_o  out  1  one-cycle write strobe
read_en_o  out  1  one-cycle read strobe
op_size_o  out  2  0=1B, 1=2B, 2=4B, 3=8B
write_data_o  out  data_width_p  write data, forwarded unchanged
read_data_i  in  data_width_p  controller read data
read_data_v_i  in  1  controller read data valid

Behaviour:
- Reset (reset_n_i low, asynchronous): state IDLE; every ready, valid, enable and resp output 0; addr_o, op_size_o, write_data_o, s_axil_rdata_o 0; timeout counter 0; grant pointer set to favour write.
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP. One transaction is in flight at a time.
- IDLE, write eligible when awvalid and wvalid are both high. awready_o and wready_o assert together, combinationally, in the same cycle; AW or W alone is never accepted.
- IDLE, read eligible when arvalid is high; arready_o asserts combinationally.
- Both eligible in the same cycle: round-robin. The granted side wins; the pointer flips to the other side after each grant. After reset, write wins the first tie.
- Write accept cycle N: latch address, data and decoded strobe. N+1 WR_ISSUE: write_en_o=1 for exactly one cycle when the strobe is legal. N+2 WR_RESP: bvalid_o=1, held until bready_i, then IDLE.
- Strobe decode. Legal patterns are naturally aligned contiguous groups:
  - all ones -> op_size 3 (64-bit only)
  - aligned 4 bytes -> 2
  - aligned 2 bytes -> 1
  - single byte -> 0
  - addr_o = awaddr aligned down to the data width, plus the byte offset of the lowest enabled lane.
- Illegal strobe (non-contiguous, misaligned, or all zero): no write_en_o pulse; WR_ISSUE passes through to WR_RESP with bresp=SLVERR.
- Read accept cycle N: latch araddr aligned down to the data width. op_size_o = full width (3 for 64-bit, 2 for 32-bit). N+1 RD_ISSUE: read_en_o=1 for one cycle. N+2 onward RD_WAIT, counter increments each cycle.
- In RD_WAIT, read_data_v_i high: register read_data_i into rdata, rresp=OKAY, go to RD_RESP (rvalid next cycle). Nominal: rvalid at N+3.
- Counter reaches timeout_p without read_data_v_i: rdata=0, rresp=SLVERR, go to RD_RESP.
- read_data_v_i in any state other than RD_WAIT (late or spurious) is ignored.
- RD_RESP: rvalid_o held with stable data and resp until rready_i, then IDLE.
- write_en_o and read_en_o are never high together and never high outside the ISSUE states.
- Address bits above addr_width_p are discarded; there is no decode error.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. A pending valid on the AXI side is re-evaluated after reset releases.

Test Plan:
- Write awaddr=0x0010, wdata=0x1122334455667788, wstrb=0xFF -> write_en_o one cycle at N+1 with addr_o=0x0010, op_size_o=3; bvalid at N+2 with bresp=00.
- Write awaddr=0x0020, wstrb=0x30 -> addr_o=0x0024, op_size_o=1, write_data_o unchanged; wstrb=0x05 -> no write_en_o pulse, bresp=10.
- Read araddr=0x0108, controller returns read_data_v_i one cycle after read_en_o with 0xDEADBEEFCAFEF00D -> rvalid at N+3 with that rdata, rresp=00; hold rready low 5 cycles -> rvalid and rdata stable throughout.
- Read with read_data_v_i never asserted, timeout_p=4 -> rvalid with rdata=0, rresp=10 after 4 RD_WAIT cycles; a later read_data_v_i pulse in IDLE -> no effect.
- AW+W and AR valid together on three consecutive transactions from reset -> grants alternate write, read, write; never two enables in one cycle.
- reset_n_i pulled low during RD_WAIT -> all outputs 0 asynchronously; after release, the next read completes normally.
